arilla_mem_responder: RTL and testbench
=======================================

Name: arilla_mem_responder

Overview:
- Responder end of the arilla bus: a word-organised on-chip memory that answers read and write requests issued by the core's memory interface.
- Decodes its own address window, inserts a configurable number of wait states, performs byte-masked writes, and returns completion or fault to the initiator.
- Sits on the system bus alongside other responders; a thin binding module connects its ports to `arilla_bus_if`.

Parameters:
- BaseAddress, 32'h0000_0000, byte address of window start; must be aligned to Size.
- Size, 4096, window size in bytes; power of two, ≥ 8.
- Latency, 1, wait-state cycles inserted between request capture and response (0–15).
- ProtectSize, 256, bytes at window start that are write-protected. Used only with the optional feature; must be ≤ Size and a multiple of 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- address  in  32  byte address from initiator; bits [1:0] ignored.
- rd  in  1  read request; held stable until complete.
- wr  in  1  write request; held stable until complete.
- byte_en  in  4  write byte lanes; bit i selects data_in[8i+7:8i].
- data_in  in  32  write data.
- data_out  out  32  read data; valid only in the complete cycle, otherwise 0.
- hit  out  1  registered: request captured and in service (WAIT/RESP).
- complete  out  1  one-cycle response pulse.
- fault  out  1  qualifies complete: request rejected.

Behaviour:
- Interface fixed: single clock `clk`; reset `rst_n`, asynchronous, active-low.
- Reset values: data_out=0, hit=0, complete=0, fault=0, state=IDLE, wait counter=0. Memory array is not reset and retains contents.
- Window match: `(address & ~(Size-1)) == BaseAddress`. Requests outside the window are ignored: no hit, no complete, state stays IDLE.
- States: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - On (rd|wr) with window match, capture address word index, rd, wr, byte_en and data_in.
  - Go to WAIT with counter=Latency-1, or go directly to RESP if Latency==0.
- WAIT: decrement counter each cycle; at 0 go to RESP.
- RESP:
  - complete=1 for exactly one cycle.
  - Read: data_out = word at captured index (array read issued on the WAIT→RESP or IDLE→RESP transition).
  - Write: lanes selected by byte_en are written on the RESP clock edge.
  - Next state is HOLD.
- HOLD:
  - One cycle in which rd/wr are ignored, so the initiator can drop its request. Next state is IDLE.
  - Back-to-back requests are therefore separated by one idle cycle.
- Latency: request to complete is Latency+1 cycles. The turnaround cost is Latency+3 cycles.
- hit is 1 while in WAIT or RESP.
- rd and wr both 1 at capture: complete=1, fault=1, no array write, data_out=0.
- Write with byte_en=0: completes normally with no array change.
- rd/wr deasserted mid-WAIT: the captured request still completes. The initiator contract forbids this; the bench flags it as a protocol violation.
- Reset mid-operation: abort immediately, outputs to reset values. Any write not yet at its RESP edge is not performed.
- Index width is log2(Size)-2. Address bits above the window are not used for indexing.

Optional Feature:
- Macro: ARILLA_MEM_WRITE_PROTECT_EN.
- With the macro: writes whose captured offset < ProtectSize respond with complete=1, fault=1 and no array change. Reads are unaffected.
- Without the macro: ProtectSize is ignored and all in-window writes are performed.

Decomposition:
- Package `arilla_mem_pkg`:
  - State enum (IDLE, WAIT, RESP, HOLD).
  - Bus widths (ADDR_W=32, DATA_W=32, BE_W=4).
  - Latency counter width (4).
  - Window-match helper function.
- Sub-module `arilla_sram_array`:
  - Synchronous single-port, word-wide, byte-write-enable array (Depth = Size/4).
  - Registered read output; no reset.
- The responder FSM, counter and decode live in `arilla_mem_responder`.

Test Plan:
- Write 0xDEADBEEF, byte_en=4'hF, to BaseAddress+0x104, Latency=2: complete exactly 3 cycles after wr is sampled, fault=0. Readback of 0x104 returns 0xDEADBEEF in the complete cycle; data_out is 0 before and after.
- Preload 0x11223344 at 0x200, then write 0xAABBCCDD with byte_en=4'b0101: readback = 0x11BB33DD.
- Request at BaseAddress+Size, i.e. out of window: hit, complete and fault stay 0 for 20 cycles; state stays IDLE.
- rd=wr=1 at 0x300: complete=1 with fault=1. The word at 0x300 is unchanged and data_out=0.
- Assert rst_n=0 in the WAIT cycle of a write of 0x12345678 to 0x40: outputs drop to 0 asynchronously. A later readback of 0x40 returns the old value.
- With ARILLA_MEM_WRITE_PROTECT_EN and ProtectSize=256:
  - Write to 0xFC gives fault=1 and the word is unchanged.
  - Write to 0x100 gives fault=0 and the word is updated.
  - Latency=0 gives complete on the cycle after the request.

Source files
------------

// File: rtl/arilla_mem_pkg.sv
// ============================================================================
// Module   : arilla_mem_pkg
// Brief    : Shared types, bus widths and window decode for the arilla memory
//            responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arilla_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // True when addr falls inside the naturally aligned window [base, base+size).
    function automatic logic window_match(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base,
                                          input int unsigned       size);
        logic [ADDR_W-1:0] w_mask;
        w_mask = ~ADDR_W'(size - 1);
        return (addr & w_mask) == base;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arilla_sram_array.sv
// ============================================================================
// Module   : arilla_sram_array
// Brief    : Single-port word-wide SRAM with byte write enables and a
//            registered read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arilla_sram_array
    import arilla_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [BE_W-1:0]   i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read-during-write returns the old word; the responder never relies on it.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (i_we[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/arilla_mem_responder.sv
// ============================================================================
// Module   : arilla_mem_responder
// Brief    : arilla bus memory responder: window decode, programmable wait
//            states, byte-masked writes, completion/fault signalling.
// Options  : ARILLA_MEM_WRITE_PROTECT_EN - fault writes below PROTECT_SIZE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arilla_mem_responder
    import arilla_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          SIZE         = 4096,
    parameter int          LATENCY      = 1,
    parameter int          PROTECT_SIZE = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              rd,
    input  logic              wr,
    input  logic [BE_W-1:0]   byte_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              hit,
    output logic              complete,
    output logic              fault
);

    localparam int c_off_w = $clog2(SIZE);
    localparam int c_idx_w = c_off_w - 2;
    localparam int c_depth = SIZE / 4;
    localparam logic [CNT_W-1:0] c_wait_init = CNT_W'(LATENCY - 1);
`ifdef ARILLA_MEM_WRITE_PROTECT_EN
    localparam logic c_protect_en = 1'b1;
`else
    localparam logic c_protect_en = 1'b0;
`endif

    state_t             r_state, w_next_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [c_idx_w-1:0] r_idx;
    logic [BE_W-1:0]    r_be;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_is_read, r_do_write, r_fault;

    logic               w_match, w_capture, w_protect;
    logic [ADDR_W-1:0]  w_offset;
    logic [c_idx_w-1:0] w_addr_idx, w_sram_idx;
    logic               w_rd_issue, w_wr_fire, w_sram_en;
    logic [BE_W-1:0]    w_sram_we;
    logic [DATA_W-1:0]  w_rdata;

    assign w_match    = window_match(address, BASE_ADDRESS, SIZE);
    assign w_capture  = (r_state == ST_IDLE) && (rd || wr) && w_match;
    assign w_offset   = address & ADDR_W'(SIZE - 1);
    assign w_protect  = c_protect_en && wr && !rd && (w_offset < ADDR_W'(PROTECT_SIZE));
    assign w_addr_idx = address[c_idx_w+1:2];

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    if (LATENCY == 0) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_cnt_next   = c_wait_init;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: w_next_state = ST_HOLD;
            ST_HOLD: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_is_read  <= 1'b0;
            r_do_write <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_idx      <= w_addr_idx;
                r_be       <= byte_en;
                r_wdata    <= data_in;
                r_is_read  <= rd && !wr;
                r_do_write <= wr && !rd && !w_protect;
                r_fault    <= (rd && wr) || w_protect;
            end
        end
    end

    // With zero latency the read launches on the capture edge, so the live
    // address index is used while still in IDLE.
    assign w_sram_idx = (r_state == ST_IDLE) ? w_addr_idx : r_idx;
    assign w_rd_issue = (w_next_state == ST_RESP);
    assign w_wr_fire  = (r_state == ST_RESP) && r_do_write;
    assign w_sram_en  = w_rd_issue || w_wr_fire;
    assign w_sram_we  = w_wr_fire ? r_be : '0;

    arilla_sram_array #(
        .DEPTH (c_depth),
        .IDX_W (c_idx_w)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_sram_en),
        .i_we    (w_sram_we),
        .i_idx   (w_sram_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign complete = (r_state == ST_RESP);
    assign fault    = complete && r_fault;
    assign hit      = (r_state == ST_WAIT) || (r_state == ST_RESP);
    assign data_out = (complete && r_is_read) ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_arilla_mem_responder.sv
// ============================================================================
// Module   : tb_arilla_mem_responder
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arilla_mem_responder;

    localparam logic [31:0] BASE_A = 32'h0001_0000;
    localparam logic [31:0] BASE_B = 32'h0000_0000;
    localparam int          SIZE   = 4096;
    localparam int          LAT_A  = 2;
    localparam int          LAT_B  = 0;
    localparam int          PSIZE  = 256;
`ifdef ARILLA_MEM_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif
    localparam logic [31:0] RST_OFF = PROT ? 32'h140 : 32'h40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0, data_in = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [3:0]  byte_en = '0;
    int          sel = 0;

    always #5 clk = ~clk;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] do_a, do_b;
    logic        hit_a, hit_b, cmp_a, cmp_b, flt_a, flt_b;
    logic [31:0] m_do;
    logic        m_hit, m_cmp, m_flt;

    assign rd_a = rd && (sel == 0);
    assign wr_a = wr && (sel == 0);
    assign rd_b = rd && (sel == 1);
    assign wr_b = wr && (sel == 1);

    always_comb begin
        m_do  = (sel == 0) ? do_a  : do_b;
        m_hit = (sel == 0) ? hit_a : hit_b;
        m_cmp = (sel == 0) ? cmp_a : cmp_b;
        m_flt = (sel == 0) ? flt_a : flt_b;
    end

    arilla_mem_responder #(.BASE_ADDRESS(BASE_A), .SIZE(SIZE), .LATENCY(LAT_A), .PROTECT_SIZE(PSIZE)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .address(address), .rd(rd_a), .wr(wr_a), .byte_en(byte_en),
        .data_in(data_in), .data_out(do_a), .hit(hit_a), .complete(cmp_a), .fault(flt_a));

    arilla_mem_responder #(.BASE_ADDRESS(BASE_B), .SIZE(SIZE), .LATENCY(LAT_B), .PROTECT_SIZE(PSIZE)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .address(address), .rd(rd_b), .wr(wr_b), .byte_en(byte_en),
        .data_in(data_in), .data_out(do_b), .hit(hit_b), .complete(cmp_b), .fault(flt_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int s);
        return (s == 0) ? BASE_A : BASE_B;
    endfunction

    // One bus transaction: checks latency, idle outputs while waiting and the
    // HOLD cycle, then returns the response seen in the complete cycle.
    task automatic txn(input int s, input logic [31:0] a, input logic r, input logic w,
                       input logic [3:0] b, input logic [31:0] d, input bit drop_mid,
                       output logic f, output logic [31:0] q);
        int lat;
        int n;
        bit done;
        bit bad;
        lat  = (s == 0) ? LAT_A : LAT_B;
        n    = 0;
        done = 1'b0;
        bad  = 1'b0;
        f    = 1'b0;
        q    = '0;
        @(negedge clk);
        sel = s; address = a; rd = r; wr = w; byte_en = b; data_in = d;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (m_cmp === 1'b1) begin
                done = 1'b1;
                f    = m_flt;
                q    = m_do;
                if (m_hit !== 1'b1) bad = 1'b1;
            end else begin
                if (m_do !== '0 || m_hit !== 1'b1 || m_flt !== 1'b0) bad = 1'b1;
                if (drop_mid && n == 1) begin rd = 1'b0; wr = 1'b0; end
            end
        end
        chk("latency", n, lat + 1);
        chk("wait_outputs", {31'b0, bad}, 0);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        chk("hold_outputs", {m_do[30:0] | {30'b0, m_hit}, m_cmp | m_flt}, 0);
        @(posedge clk);
    endtask

    typedef struct {
        int          s;
        logic [31:0] off;
        logic        r;
        logic        w;
        logic [3:0]  be;
        logic [31:0] d;
        logic        ef;
        logic [31:0] eq;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] mdl [2][1024];

    initial begin
        logic        f;
        logic [31:0] q, exp_q;
        bit          bad;
        int          c1, c2, n;

        vecs[0]  = '{0, 32'h104, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{0, 32'h104, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{0, 32'h200, 1'b0, 1'b1, 4'hF, 32'h11223344, 1'b0, 32'h0};
        vecs[3]  = '{0, 32'h200, 1'b0, 1'b1, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0};
        vecs[4]  = '{0, 32'h200, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h11BB33DD};
        vecs[5]  = '{0, 32'h300, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[6]  = '{0, 32'h300, 1'b1, 1'b1, 4'hF, 32'h0,        1'b1, 32'h0};
        vecs[7]  = '{0, 32'h300, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
        vecs[8]  = '{0, 32'h300, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[9]  = '{0, 32'h300, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
        vecs[10] = '{1, 32'h120, 1'b0, 1'b1, 4'hF, 32'h01020304, 1'b0, 32'h0};
        vecs[11] = '{1, 32'h120, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h01020304};

        // Reset values
        #12;
        chk("reset_a", {do_a[28:0], hit_a, cmp_a, flt_a}, 0);
        chk("reset_b", {do_b[28:0], hit_b, cmp_b, flt_b}, 0);
        chk("reset_data_a", do_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Out-of-window requests are ignored
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sel = 0;
            address = (k == 1) ? BASE_A - 32'd4 : BASE_A + SIZE;
            rd = (k != 2); wr = (k == 2); byte_en = 4'hF; data_in = 32'h5555AAAA;
            bad = 1'b0;
            repeat (20) begin
                @(posedge clk); #1;
                if (m_hit !== 1'b0 || m_cmp !== 1'b0 || m_flt !== 1'b0 || m_do !== '0) bad = 1'b1;
            end
            chk("out_of_window", {31'b0, bad}, 0);
            @(negedge clk);
            rd = 1'b0; wr = 1'b0;
        end

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].s, base_of(vecs[i].s) + vecs[i].off, vecs[i].r, vecs[i].w,
                vecs[i].be, vecs[i].d, 1'b0, f, q);
            chk($sformatf("vec%0d_fault", i), {31'b0, f}, {31'b0, vecs[i].ef});
            chk($sformatf("vec%0d_data", i), q, vecs[i].eq);
        end

        // Back-to-back reads with the request held: second completes Latency+3 later
        @(negedge clk);
        sel = 0; address = BASE_A + 32'h104; rd = 1'b1; wr = 1'b0;
        c1 = 0; c2 = 0; n = 0;
        while (c2 == 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (m_cmp === 1'b1) begin
                if (c1 == 0) c1 = n; else c2 = n;
            end
        end
        chk("b2b_first", c1, LAT_A + 1);
        chk("b2b_second", c2, 2 * LAT_A + 4);
        @(negedge clk);
        rd = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in the WAIT cycle aborts the write
        txn(0, BASE_A + RST_OFF, 1'b0, 1'b1, 4'hF, 32'h0BADF00D, 1'b0, f, q);
        chk("rst_preload_fault", {31'b0, f}, 0);
        @(negedge clk);
        sel = 0; address = BASE_A + RST_OFF; rd = 1'b0; wr = 1'b1; byte_en = 4'hF; data_in = 32'h12345678;
        @(posedge clk); #1;
        chk("rst_in_wait_hit", {31'b0, hit_a}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {do_a[28:0], hit_a, cmp_a, flt_a}, 0);
        @(negedge clk);
        wr = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        txn(0, BASE_A + RST_OFF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, f, q);
        chk("rst_aborted_write", q, 32'h0BADF00D);

        // Request dropped mid-WAIT still completes
        $display("note: protocol violation injected, request dropped during WAIT");
        txn(0, BASE_A + 32'h500, 1'b0, 1'b1, 4'hF, 32'h77778888, 1'b1, f, q);
        chk("drop_mid_fault", {31'b0, f}, 0);
        txn(0, BASE_A + 32'h500, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, f, q);
        chk("drop_mid_data", q, 32'h77778888);

        // Write-protect boundary
        txn(0, BASE_A + 32'hFC, 1'b0, 1'b1, 4'hF, 32'h5A5A5A5A, 1'b0, f, q);
        chk("prot_fc_fault", {31'b0, f}, {31'b0, PROT});
        txn(0, BASE_A + 32'hFC, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, f, q);
        if (PROT) chk("prot_fc_unchanged", {31'b0, q !== 32'h5A5A5A5A}, 1);
        else      chk("prot_fc_written", q, 32'h5A5A5A5A);
        txn(0, BASE_A + 32'h100, 1'b0, 1'b1, 4'hF, 32'hA5A5A5A5, 1'b0, f, q);
        chk("prot_100_fault", {31'b0, f}, 0);
        txn(0, BASE_A + 32'h100, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, f, q);
        chk("prot_100_data", q, 32'hA5A5A5A5);

        // Randomized traffic against the word model: fill, then mixed ops
        for (int s = 0; s < 2; s++) begin
            for (int w = 256; w < 272; w++) begin
                mdl[s][w] = $urandom;
                txn(s, base_of(s) + 32'(w * 4), 1'b0, 1'b1, 4'hF, mdl[s][w], 1'b0, f, q);
                chk("fill_fault", {31'b0, f}, 0);
            end
        end
        for (int it = 0; it < 60; it++) begin
            int          s, w, op;
            logic        r, wv, ef;
            logic [3:0]  be;
            logic [31:0] d;
            s  = $urandom_range(0, 1);
            w  = 256 + $urandom_range(0, 15);
            op = $urandom_range(0, 3);
            r  = (op <= 1) || (op == 3);
            wv = (op >= 2);
            be = 4'($urandom);
            d  = $urandom;
            ef = r && wv;
            exp_q = (r && !wv) ? mdl[s][w] : 32'h0;
            txn(s, base_of(s) + 32'(w * 4) + 32'($urandom_range(0, 3)), r, wv, be, d, 1'b0, f, q);
            chk($sformatf("rand%0d_fault", it), {31'b0, f}, {31'b0, ef});
            chk($sformatf("rand%0d_data", it), q, exp_q);
            if (wv && !r) begin
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) mdl[s][w][8*l +: 8] = d[8*l +: 8];
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
